// File: rtl/if_id_queue_pkg.sv
// Shared constants for the fetch/decode decoupling queue: datapath widths,
// the NOP encoding and the opcodes of control-transfer instructions.
package if_id_queue_pkg;

    localparam int CPU_WIDTH  = 64;
    localparam int INST_WIDTH = 32;

    localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    function automatic logic is_ctrl_opcode(input logic [6:0] opcode);
        return (opcode == OPC_BRANCH) || (opcode == OPC_JAL) || (opcode == OPC_JALR);
    endfunction

endpackage

// File: rtl/ifq_predecode.sv
// Combinational predecode: flags branch, jal and jalr opcodes so decode
// learns early that the head instruction can redirect the PC.
module ifq_predecode
    import if_id_queue_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic       o_is_ctrl
);

    assign o_is_ctrl = is_ctrl_opcode(i_opcode);

endmodule

// File: rtl/if_id_queue.sv
// In-order instruction queue between fetch and decode with single-cycle flush.
// Define IFQ_PREDECODE_EN to store a per-entry control-transfer flag (id_is_ctrl).
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    if_valid,
    input  logic [INST_WIDTH-1:0]   if_inst,
    input  logic [CPU_WIDTH-1:0]    if_pc,
    output logic                    if_ready,
    output logic                    id_valid,
    output logic [INST_WIDTH-1:0]   id_inst,
    output logic [CPU_WIDTH-1:0]    id_pc,
    input  logic                    id_ready,
`ifdef IFQ_PREDECODE_EN
    output logic                    id_is_ctrl,
`endif
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [INST_WIDTH-1:0] r_inst_mem [DEPTH];
    logic [CPU_WIDTH-1:0]  r_pc_mem   [DEPTH];
    logic [AW:0]           r_wptr;
    logic [AW:0]           r_rptr;
    logic [AW:0]           r_count;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_widx;
    logic [AW-1:0] w_ridx;

    assign w_widx  = r_wptr[AW-1:0];
    assign w_ridx  = r_rptr[AW-1:0];
    assign w_empty = (r_wptr == r_rptr);
    // Same slot with opposite wrap bits means the writer is a full lap ahead.
    assign w_full  = (w_widx == w_ridx) && (r_wptr[AW] != r_rptr[AW]);

    assign if_ready = !w_full && !flush;
    assign id_valid = !w_empty && !flush;
    assign w_push   = if_valid && if_ready;
    assign w_pop    = id_valid && id_ready;

    assign id_inst  = w_empty ? NOP_INST : r_inst_mem[w_ridx];
    assign id_pc    = w_empty ? '0 : r_pc_mem[w_ridx];
    assign count    = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst_mem[w_widx] <= if_inst;
            r_pc_mem[w_widx]   <= if_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + PTR_ONE;
                2'b01:   r_count <= r_count - PTR_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef IFQ_PREDECODE_EN
    logic r_ctrl_mem [DEPTH];
    logic w_in_is_ctrl;

    ifq_predecode u_predecode (
        .i_opcode  (if_inst[6:0]),
        .o_is_ctrl (w_in_is_ctrl)
    );

    always_ff @(posedge clk) begin
        if (w_push) r_ctrl_mem[w_widx] <= w_in_is_ctrl;
    end

    assign id_is_ctrl = w_empty ? 1'b0 : r_ctrl_mem[w_ridx];
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Randomized and directed bench for if_id_queue, checked against a queue model.
// Inputs change just after the rising edge; the model samples at the falling edge.
module tb_if_id_queue;

    localparam int DEPTH = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   if_valid;
    logic [31:0]            if_inst;
    logic [63:0]            if_pc;
    logic                   if_ready;
    logic                   id_valid;
    logic [31:0]            id_inst;
    logic [63:0]            id_pc;
    logic                   id_ready;
    logic                   flush;
    logic [$clog2(DEPTH):0] count;
`ifdef IFQ_PREDECODE_EN
    logic                   id_is_ctrl;
`endif

    int n_vectors     = 0;
    int n_miscompares = 0;

    // Each entry is {pc, inst}, in fetch order.
    logic [95:0] exp_q[$];

    always #5 clk = ~clk;

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_valid),
        .if_inst    (if_inst),
        .if_pc      (if_pc),
        .if_ready   (if_ready),
        .id_valid   (id_valid),
        .id_inst    (id_inst),
        .id_pc      (id_pc),
        .id_ready   (id_ready),
`ifdef IFQ_PREDECODE_EN
        .id_is_ctrl (id_is_ctrl),
`endif
        .flush      (flush),
        .count      (count)
    );

    function automatic logic exp_ctrl(input logic [31:0] inst);
        return (inst[6:0] == 7'b1100011) || (inst[6:0] == 7'b1101111) ||
               (inst[6:0] == 7'b1100111);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                         input logic rdy, input logic fl);
        @(posedge clk);
        #1;
        if_valid = v;
        if_inst  = inst;
        if_pc    = pc;
        id_ready = rdy;
        flush    = fl;
    endtask

    task automatic async_reset();
        @(posedge clk);
        #1;
        if_valid = 1'b0;
        id_ready = 1'b0;
        flush    = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("areset_id_valid", {63'd0, id_valid}, 64'd0);
        chk("areset_if_ready", {63'd0, if_ready}, 64'd1);
        chk("areset_count", 64'(count), 64'd0);
        chk("areset_id_inst", {32'd0, id_inst}, 64'h13);
        chk("areset_id_pc", id_pc, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Reference model and scoreboard: compare the visible state, then apply
    // the upcoming edge's push/pop/flush to the model queue.
    always @(negedge clk) begin
        logic        m_ready;
        logic        m_valid;
        logic [95:0] head;
        if (!rst_n) begin
            exp_q.delete();
            chk("rst_id_valid", {63'd0, id_valid}, 64'd0);
            chk("rst_if_ready", {63'd0, if_ready}, 64'd1);
            chk("rst_count", 64'(count), 64'd0);
            chk("rst_id_inst", {32'd0, id_inst}, 64'h13);
        end else begin
            m_ready = (exp_q.size() < DEPTH) && !flush;
            m_valid = (exp_q.size() != 0) && !flush;
            chk("if_ready", {63'd0, if_ready}, {63'd0, m_ready});
            chk("id_valid", {63'd0, id_valid}, {63'd0, m_valid});
            chk("count", 64'(count), 64'(exp_q.size()));
            if (exp_q.size() != 0) begin
                head = exp_q[0];
                chk("id_pc", id_pc, head[95:32]);
                chk("id_inst", {32'd0, id_inst}, {32'd0, head[31:0]});
`ifdef IFQ_PREDECODE_EN
                chk("id_is_ctrl", {63'd0, id_is_ctrl}, {63'd0, exp_ctrl(head[31:0])});
`endif
            end else begin
                chk("empty_id_pc", id_pc, 64'd0);
                chk("empty_id_inst", {32'd0, id_inst}, 64'h13);
`ifdef IFQ_PREDECODE_EN
                chk("empty_id_is_ctrl", {63'd0, id_is_ctrl}, 64'd0);
`endif
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                if (m_valid && id_ready) head = exp_q.pop_front();
                if (if_valid && m_ready) exp_q.push_back({if_pc, if_inst});
            end
        end
    end

    initial begin
        logic [63:0] pc;
        logic [31:0] inst;
        rst_n    = 1'b0;
        if_valid = 1'b0;
        if_inst  = 32'h0;
        if_pc    = 64'h0;
        id_ready = 1'b0;
        flush    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill to full with decode stalled; the third offer must be refused.
        drive(1'b1, 32'h0000_0093, 64'h8000_0000, 1'b0, 1'b0);
        drive(1'b1, 32'h0010_0113, 64'h8000_0004, 1'b0, 1'b0);
        drive(1'b1, 32'h0020_0193, 64'h8000_0008, 1'b0, 1'b0);
        drive(1'b1, 32'h0020_0193, 64'h8000_0008, 1'b0, 1'b0);
        // Back-pressure release for one cycle, then drain.
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);

        // Streaming push and pop every cycle across several pointer laps.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h0000_0013 | (32'(i) << 20), 64'h8000_1000 + 64'(4 * i), 1'b1, 1'b0);
        end
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);

        // Flush while pushing and popping at count=1.
        drive(1'b1, 32'h0030_0213, 64'h8000_2000, 1'b0, 1'b0);
        drive(1'b1, 32'h0040_0293, 64'h8000_2004, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);

        // Control-transfer predecode: jal then NOP.
        drive(1'b1, 32'h0000_006F, 64'h8000_3000, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_0013, 64'h8000_3004, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);

        // Asynchronous reset mid-run with the queue full.
        drive(1'b1, 32'h0050_0313, 64'h8000_4000, 1'b0, 1'b0);
        drive(1'b1, 32'h0060_0393, 64'h8000_4004, 1'b0, 1'b0);
        async_reset();

        // Randomized traffic with occasional redirects.
        pc = 64'h8001_0000;
        for (int i = 0; i < 500; i++) begin
            inst = $urandom;
            case ($urandom_range(0, 5))
                0: inst[6:0] = 7'b1100011;
                1: inst[6:0] = 7'b1101111;
                2: inst[6:0] = 7'b1100111;
                default: ;
            endcase
            drive(1'($urandom_range(0, 1)), inst, pc, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 19) == 0));
            pc = pc + 64'd4;
        end
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        repeat (DEPTH + 1) drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
